// File: rtl/ssb_bus_arbiter_if.sv
// Host/device bundle for the shared system bus arbiter.
// The master side is the hosts plus devices; the slave side is the arbiter.
interface ssb_bus_arbiter_if;
    logic [2:0]  host_req_i;
    logic [2:0]  host_gnt_o;
    logic [2:0]  host_rvalid_o;
    logic [2:0]  host_err_o;
    logic [95:0] host_addr_i;
    logic [2:0]  host_we_i;
    logic [11:0] host_be_i;
    logic [95:0] host_wdata_i;
    logic [31:0] host_rdata_o;
    logic [1:0]  dev_req_o;
    logic [31:0] dev_addr_o;
    logic        dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_wdata_o;
    logic [63:0] dev_rdata_i;

    modport master (
        output host_req_i, host_addr_i, host_we_i,
        output host_be_i, host_wdata_i, dev_rdata_i,
        input  host_gnt_o, host_rvalid_o, host_err_o,
        input  host_rdata_o, dev_req_o, dev_addr_o,
        input  dev_we_o, dev_be_o, dev_wdata_o
    );

    modport slave (
        input  host_req_i, host_addr_i, host_we_i,
        input  host_be_i, host_wdata_i, dev_rdata_i,
        output host_gnt_o, host_rvalid_o, host_err_o,
        output host_rdata_o, dev_req_o, dev_addr_o,
        output dev_we_o, dev_be_o, dev_wdata_o
    );
endinterface

// File: rtl/ssb_bus_arbiter.sv
// Three-host bus arbiter with age promotion, SRAM/debug decode
// and a one-cycle registered response path.
module ssb_bus_arbiter #(
    parameter logic [31:0] SramStart = 32'h0000_0000,
    parameter logic [31:0] SramMask  = 32'h0000_FFFF,
    parameter logic [31:0] DbgStart  = 32'h1A11_0000,
    parameter logic [31:0] DbgMask   = 32'h0000_FFFF,
    parameter int unsigned MaxWait   = 8
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    ssb_bus_arbiter_if.slave bus
);
    localparam logic [7:0] WaitMax = 8'(MaxWait);

    logic [7:0]  r_wait [3];
    logic [2:0]  r_resp_host;
    logic        r_resp_dev;
    logic        r_resp_err;
    logic        r_resp_we;

    logic [2:0]  w_prom;
    logic [2:0]  w_cand;
    logic [2:0]  w_gnt;
    logic        w_any;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_we;
    logic        w_sram_hit;
    logic        w_dbg_hit;
    logic        w_err;
    logic [31:0] w_rdata_sel;

    // Promoted hosts take over the candidate set; lowest index wins.
    always_comb begin
        w_prom = '0;
        for (int h = 0; h < 3; h++) begin
            w_prom[h] = bus.host_req_i[h] && (r_wait[h] == WaitMax);
        end
        w_cand = (|w_prom) ? w_prom : bus.host_req_i;
        w_gnt  = rst_sys_i ? 3'b000 : (w_cand & (~w_cand + 3'd1));
    end

    assign w_any = |w_gnt;

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        w_we    = 1'b0;
        unique case (1'b1)
            w_gnt[0]: begin
                w_addr  = bus.host_addr_i[31:0];
                w_wdata = bus.host_wdata_i[31:0];
                w_be    = bus.host_be_i[3:0];
                w_we    = bus.host_we_i[0];
            end
            w_gnt[1]: begin
                w_addr  = bus.host_addr_i[63:32];
                w_wdata = bus.host_wdata_i[63:32];
                w_be    = bus.host_be_i[7:4];
                w_we    = 1'b0;
            end
            w_gnt[2]: begin
                w_addr  = bus.host_addr_i[95:64];
                w_wdata = bus.host_wdata_i[95:64];
                w_be    = bus.host_be_i[11:8];
                w_we    = bus.host_we_i[2];
            end
            default: ;
        endcase
    end

    assign w_sram_hit = w_any && ((w_addr & ~SramMask) == SramStart);
    assign w_dbg_hit  = w_any && ((w_addr & ~DbgMask) == DbgStart);
    assign w_err      = w_any && !w_sram_hit && !w_dbg_hit;

    // Overlapping windows are a configuration error.
    always_comb begin
        assert (!(w_sram_hit && w_dbg_hit));
    end

    assign bus.host_gnt_o  = w_gnt;
    assign bus.dev_req_o   = {w_dbg_hit & ~w_sram_hit, w_sram_hit};
    assign bus.dev_addr_o  = w_addr;
    assign bus.dev_we_o    = w_we;
    assign bus.dev_be_o    = w_be;
    assign bus.dev_wdata_o = w_wdata;

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int h = 0; h < 3; h++) begin
                r_wait[h] <= '0;
            end
        end else begin
            for (int h = 0; h < 3; h++) begin
                if (!bus.host_req_i[h] || w_gnt[h]) begin
                    r_wait[h] <= '0;
                end else if (r_wait[h] != WaitMax) begin
                    r_wait[h] <= r_wait[h] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_resp_host <= '0;
            r_resp_dev  <= 1'b0;
            r_resp_err  <= 1'b0;
            r_resp_we   <= 1'b0;
        end else begin
            r_resp_host <= w_gnt;
            r_resp_dev  <= w_dbg_hit & ~w_sram_hit;
            r_resp_err  <= w_err;
            r_resp_we   <= w_we;
        end
    end

    assign w_rdata_sel = r_resp_dev ? bus.dev_rdata_i[63:32]
                                    : bus.dev_rdata_i[31:0];

    assign bus.host_rvalid_o = r_resp_host;
    assign bus.host_err_o    = r_resp_err ? r_resp_host : 3'b000;
    assign bus.host_rdata_o  =
        (|r_resp_host && !r_resp_err && !r_resp_we) ? w_rdata_sel : '0;
endmodule

// File: tb/tb_ssb_bus_arbiter.sv
// Directed and randomized checks of ssb_bus_arbiter against
// a transaction-level reference model.
module tb_ssb_bus_arbiter;
    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ssb_bus_arbiter_if bus();

    ssb_bus_arbiter #(.MaxWait(MAXW)) dut (
        .clk_sys_i(clk),
        .rst_sys_i(rst),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: per-host waiting age and the one outstanding response.
    int wcnt [3];
    bit pv;
    int ph;
    int pd;
    bit pw;

    function automatic int pick(logic [2:0] req, logic r);
        if (r) return -1;
        for (int h = 0; h < 3; h++)
            if (req[h] && wcnt[h] == MAXW) return h;
        for (int h = 0; h < 3; h++)
            if (req[h]) return h;
        return -1;
    endfunction

    function automatic int decode(logic [31:0] a);
        if ((a & ~32'h0000_FFFF) == 32'h0000_0000) return 0;
        if ((a & ~32'h0000_FFFF) == 32'h1A11_0000) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return {16'h0000, r[15:0]};
            1: return {16'h1A11, r[15:0]};
            2: return {8'h20, r[23:0]};
            default: return r;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [2:0] req, logic [31:0] a0,
                         logic [31:0] a1, logic [31:0] a2,
                         logic [2:0] we, logic [63:0] drd);
        bus.host_req_i   = req;
        bus.host_addr_i  = {a2, a1, a0};
        bus.host_we_i    = we;
        bus.host_be_i    = 12'($urandom);
        bus.host_wdata_i = {32'($urandom), 32'($urandom), 32'($urandom)};
        bus.dev_rdata_i  = drd;
    endtask

    task automatic check_now();
        int g;
        int d;
        logic [31:0] a;
        logic [2:0]  eg;
        logic [1:0]  edr;
        logic [31:0] ed;
        logic [3:0]  eb;
        logic [31:0] ew;
        logic        ewe;
        logic [2:0]  erv;
        logic [2:0]  eer;
        logic [31:0] erd;
        #2;
        if (rst) begin
            wcnt = '{0, 0, 0};
            pv = 1'b0;
        end
        g = pick(bus.host_req_i, rst);
        eg = '0; edr = '0; ed = '0; eb = '0; ew = '0; ewe = 1'b0;
        if (g >= 0) begin
            eg  = 3'(1 << g);
            a   = bus.host_addr_i[g*32 +: 32];
            d   = decode(a);
            edr = (d == 0) ? 2'b01 : (d == 1) ? 2'b10 : 2'b00;
            ed  = a;
            eb  = bus.host_be_i[g*4 +: 4];
            ew  = bus.host_wdata_i[g*32 +: 32];
            ewe = (g != 1) && bus.host_we_i[g];
        end
        erv = pv ? 3'(1 << ph) : 3'b000;
        eer = (pv && pd == 2) ? erv : 3'b000;
        erd = '0;
        if (pv && pd != 2 && !pw)
            erd = (pd == 0) ? bus.dev_rdata_i[31:0] : bus.dev_rdata_i[63:32];
        chk("gnt",    64'(bus.host_gnt_o),    64'(eg));
        chk("dev_req", 64'(bus.dev_req_o),    64'(edr));
        chk("dev_addr", 64'(bus.dev_addr_o),  64'(ed));
        chk("dev_be", 64'(bus.dev_be_o),      64'(eb));
        chk("dev_wdata", 64'(bus.dev_wdata_o), 64'(ew));
        chk("dev_we", 64'(bus.dev_we_o),      64'(ewe));
        chk("rvalid", 64'(bus.host_rvalid_o), 64'(erv));
        chk("err",    64'(bus.host_err_o),    64'(eer));
        chk("rdata",  64'(bus.host_rdata_o),  64'(erd));
    endtask

    task automatic adv();
        int g;
        g = pick(bus.host_req_i, rst);
        @(posedge clk);
        if (rst) begin
            wcnt = '{0, 0, 0};
            pv = 1'b0;
        end else begin
            for (int h = 0; h < 3; h++) begin
                if (!bus.host_req_i[h] || g == h) wcnt[h] = 0;
                else if (wcnt[h] < MAXW) wcnt[h]++;
            end
            pv = (g >= 0);
            if (pv) begin
                ph = g;
                pd = decode(bus.host_addr_i[g*32 +: 32]);
                pw = (g != 1) && bus.host_we_i[g];
            end
        end
        @(negedge clk);
    endtask

    initial begin
        wcnt = '{0, 0, 0};
        pv = 1'b0; ph = 0; pd = 0; pw = 1'b0;
        drive(3'b111, 32'h10, 32'h20, 32'h30, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check_now();
        chk("rst_gnt", 64'(bus.host_gnt_o), 64'd0);
        adv();
        rst = 1'b0;

        // Data write to SRAM
        drive(3'b100, 0, 0, 32'h100, 3'b100, 64'd0);
        bus.host_be_i[11:8] = 4'hF;
        bus.host_wdata_i[95:64] = 32'h1234_5678;
        check_now();
        chk("t1_gnt", 64'(bus.host_gnt_o), 64'b100);
        chk("t1_req", 64'(bus.dev_req_o), 64'b01);
        chk("t1_we", 64'(bus.dev_we_o), 64'd1);
        chk("t1_wd", 64'(bus.dev_wdata_o), 64'h1234_5678);
        adv();
        drive(3'b000, 0, 0, 0, 3'b000, 64'hAAAA_BBBB_CCCC_DDDD);
        check_now();
        chk("t1_rv", 64'(bus.host_rvalid_o), 64'b100);
        chk("t1_err", 64'(bus.host_err_o), 64'd0);
        chk("t1_rd", 64'(bus.host_rdata_o), 64'd0);
        adv();

        // Three simultaneous requesters, held until granted
        drive(3'b111, 32'h4, 32'h8, 32'hC, 3'b000, 64'h1);
        check_now();
        chk("t2_g0", 64'(bus.host_gnt_o), 64'b001);
        adv();
        drive(3'b110, 32'h4, 32'h8, 32'hC, 3'b000, 64'h2);
        check_now();
        chk("t2_g1", 64'(bus.host_gnt_o), 64'b010);
        chk("t2_r0", 64'(bus.host_rvalid_o), 64'b001);
        adv();
        drive(3'b100, 32'h4, 32'h8, 32'hC, 3'b000, 64'h3);
        check_now();
        chk("t2_g2", 64'(bus.host_gnt_o), 64'b100);
        chk("t2_r1", 64'(bus.host_rvalid_o), 64'b010);
        adv();
        drive(3'b000, 0, 0, 0, 3'b000, 64'h4);
        check_now();
        chk("t2_r2", 64'(bus.host_rvalid_o), 64'b100);
        adv();

        // Age promotion of the data host
        for (int c = 0; c < 11; c++) begin
            drive(3'b110, 0, 32'h40, 32'h80, 3'b000, 64'($urandom));
            check_now();
            if (c < 8)
                chk("t3_instr", 64'(bus.host_gnt_o), 64'b010);
            else if (c == 8)
                chk("t3_data", 64'(bus.host_gnt_o), 64'b100);
            else
                chk("t3_after", 64'(bus.host_gnt_o), 64'b010);
            adv();
        end
        drive(3'b000, 0, 0, 0, 3'b000, 64'd0);
        check_now();
        adv();

        // Unmapped read
        drive(3'b100, 0, 0, 32'h2000_0000, 3'b000, 64'd0);
        check_now();
        chk("t4_gnt", 64'(bus.host_gnt_o), 64'b100);
        chk("t4_req", 64'(bus.dev_req_o), 64'b00);
        adv();
        drive(3'b000, 0, 0, 0, 3'b000, 64'h5555_5555_6666_6666);
        check_now();
        chk("t4_rv", 64'(bus.host_rvalid_o), 64'b100);
        chk("t4_err", 64'(bus.host_err_o), 64'b100);
        chk("t4_rd", 64'(bus.host_rdata_o), 64'd0);
        adv();

        // Debug memory read by the SBA host
        drive(3'b001, 32'h1A11_0800, 0, 0, 3'b000, 64'hDEAD_BEEF_1111_1111);
        check_now();
        chk("t5_req", 64'(bus.dev_req_o), 64'b10);
        adv();
        drive(3'b000, 0, 0, 0, 3'b000, 64'hDEAD_BEEF_1111_1111);
        check_now();
        chk("t5_rv", 64'(bus.host_rvalid_o), 64'b001);
        chk("t5_rd", 64'(bus.host_rdata_o), 64'hDEAD_BEEF);
        adv();

        // Reset while a response is pending
        drive(3'b100, 0, 0, 32'h200, 3'b000, 64'd0);
        check_now();
        chk("t6_gnt", 64'(bus.host_gnt_o), 64'b100);
        adv();
        rst = 1'b1;
        drive(3'b011, 32'h4, 32'h8, 0, 3'b001, 64'h7777_7777_8888_8888);
        check_now();
        chk("t6_rv", 64'(bus.host_rvalid_o), 64'd0);
        chk("t6_rd", 64'(bus.host_rdata_o), 64'd0);
        adv();
        rst = 1'b0;
        drive(3'b000, 0, 0, 0, 3'b000, 64'h9999_9999_9999_9999);
        check_now();
        chk("t6_post", 64'(bus.host_rvalid_o), 64'd0);
        adv();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            logic [2:0] rq;
            for (int h = 0; h < 3; h++)
                rq[h] = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            drive(rq, rnd_addr(), rnd_addr(), rnd_addr(),
                  3'($urandom), {32'($urandom), 32'($urandom)});
            check_now();
            adv();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
